osc_phase_accum: RTL and testbench
==================================

Name: osc_phase_accum

Overview:
- Time-multiplexed phase accumulator directly downstream of the pitch stage.
- Once per sample frame it walks every voice/oscillator slot and drives the slot index to the pitch stage. It takes the combinational 24-bit pitch increment back in the same cycle and adds it into a per-slot phase register.
- It emits the updated phase to the waveform lookup stage.
- It also implements key-sync: phase reset of a voice's oscillators on note-on.

Parameters:
VOICES, 8, number of voices
V_OSC, 4, oscillators per voice
V_WIDTH, 3, log2(VOICES)
O_WIDTH, 2, log2(V_OSC)
PH_WIDTH, 32, phase accumulator width (>= 24)

Ports:
iCLK  input  1  system clock, all state on rising edge
iRST_N  input  1  asynchronous active-low reset
sample_tick  input  1  one-cycle pulse, starts a frame
osc_pitch_val  input  24  unsigned phase increment for slot currently on slot_adr (same-cycle combinational return)
note_on  input  1  one-cycle key-sync request
cur_key_adr  input  V_WIDTH  voice index for note_on
slot_adr  output  V_WIDTH+O_WIDTH  {voice,osc} index presented to pitch stage
phase_out  output  PH_WIDTH  updated phase of phase_slot
phase_slot  output  V_WIDTH+O_WIDTH  slot of phase_out
phase_valid  output  1  phase_out/phase_slot/wrap valid this cycle
wrap  output  1  accumulator overflowed on this update (waveform cycle start)
busy  output  1  frame in progress
overrun  output  1  sticky: sample_tick arrived while busy

Behaviour:
- Reset (async, iRST_N low):
  - all phase registers 0; pending-sync bits 0; slot counter 0; state IDLE.
  - slot_adr=0, phase_out=0, phase_slot=0, phase_valid=0, wrap=0, busy=0, overrun=0.
- States: IDLE, RUN.
  - IDLE: slot_adr held 0. sample_tick -> RUN next edge; counter=0.
  - RUN: slot_adr=counter. Each cycle, capture slot_adr into slot_r and osc_pitch_val into pitch_r, then increment counter.
  - After slot VOICES*V_OSC-1 is captured -> IDLE, counter=0.
  - busy=1 exactly while in RUN.
- Frame length: VOICES*V_OSC cycles (32 default). Minimum sample_tick period is 33 cycles.
- Update stage, one cycle after capture:
  - sum = phase[slot_r] + zero-extended pitch_r, modulo 2^PH_WIDTH.
  - write sum back to phase[slot_r]; phase_out=sum; phase_slot=slot_r; phase_valid=1.
  - wrap = carry out of the add.
- Latency: phase_valid for slot s asserts one cycle after slot_adr=s. Results arrive in slot order 0..31, one per cycle, with no gaps. phase_valid=0 otherwise.
- No read/write hazard: each slot is updated once per frame.
- Key-sync: pending bit per slot.
  - note_on sets the V_OSC pending bits of voice cur_key_adr.
  - When a slot with pending=1 is updated: phase written = 0 + pitch_r (phase restarts), wrap=1, and the bit is cleared.
  - Set and clear in the same cycle on the same bit: set wins, so the bit stays pending for next frame.
  - note_on during IDLE takes effect in the next frame.
- sample_tick while busy: ignored; frame is not restarted; overrun set to 1 and held until reset.
- sample_tick coincident with the last RUN cycle: also treated as busy (ignored, overrun set).
- Pitch value 0: phase holds, wrap=0 (unless sync is pending).
- Reset asserted mid-frame: immediate abort, all state returns to reset values, and no partial writes persist.

Optional Feature:
- Macro KEY_SYNC_EN.
- Defined: key-sync behaviour as above.
- Undefined: no pending bits are built; note_on and cur_key_adr are ignored (ports remain); oscillators free-run; wrap reflects carry only.

Test Plan:
- Reset then one sample_tick with osc_pitch_val=24'h000100 constant -> 32 consecutive phase_valid cycles starting 2 cycles after the tick. phase_slot 0..31, phase_out=32'h100, wrap=0. busy high for 32 cycles.
- Second tick, same pitch -> every phase_out=32'h200.
- Pitch 24'hFFFFFF for 257 frames on slot 5 -> phase wraps. Check the wrap pulse on the overflowing frame and the phase_out modulo value (257*0xFFFFFF mod 2^32).
- After 3 frames of pitch 24'h000100, note_on with cur_key_adr=2 in IDLE, then tick -> slots 8..11 output 32'h100 with wrap=1; all other slots output 32'h400.
- note_on for voice 2 in the same cycle slot 9 is captured -> slots 10,11 reset this frame; slots 8..11 all reset again next frame (set wins).
- sample_tick 10 cycles into a frame -> the frame completes normally with 32 outputs, overrun=1 and stays 1. iRST_N low mid-frame -> all outputs 0 at once and the next frame's phases start from 0.

Source files
------------

// File: rtl/osc_phase_accum.sv
// osc_phase_accum: time-multiplexed per-slot phase accumulator.
// Optional key-sync on note-on is built only when KEY_SYNC_EN is defined.
module osc_phase_accum #(
  parameter int VOICES   = 8,
  parameter int V_OSC    = 4,
  parameter int V_WIDTH  = 3,
  parameter int O_WIDTH  = 2,
  parameter int PH_WIDTH = 32
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic                       sample_tick,
  input  logic [23:0]                osc_pitch_val,
  input  logic                       note_on,
  input  logic [V_WIDTH-1:0]         cur_key_adr,
  output logic [V_WIDTH+O_WIDTH-1:0] slot_adr,
  output logic [PH_WIDTH-1:0]        phase_out,
  output logic [V_WIDTH+O_WIDTH-1:0] phase_slot,
  output logic                       phase_valid,
  output logic                       wrap,
  output logic                       busy,
  output logic                       overrun
);

  localparam int SW    = V_WIDTH + O_WIDTH;
  localparam int SLOTS = VOICES * V_OSC;

  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]          state;
  logic [SW-1:0]       counter;
  logic                overrun_q;
  logic [SW-1:0]       slot_r;
  logic [23:0]         pitch_r;
  logic                cap_v;
  logic [PH_WIDTH-1:0] phase_q [SLOTS];
  logic                sync_hit;
  logic [PH_WIDTH-1:0] base;
  logic [PH_WIDTH:0]   add_w;

  assign busy     = (state == RUN);
  assign slot_adr = busy ? counter : '0;
  assign overrun  = overrun_q;

  // Frame sequencer: walk all slots once per sample_tick
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      counter   <= '0;
      overrun_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          counter <= '0;
          if (sample_tick) state <= RUN;
        end
        RUN: begin
          if (sample_tick) overrun_q <= 1'b1;
          if (counter == LAST_SLOT) begin
            state   <= IDLE;
            counter <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

  // Capture slot index and the same-cycle pitch return
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      slot_r  <= '0;
      pitch_r <= '0;
      cap_v   <= 1'b0;
    end else begin
      cap_v <= busy;
      if (busy) begin
        slot_r  <= counter;
        pitch_r <= osc_pitch_val;
      end
    end
  end

`ifdef KEY_SYNC_EN
  logic [SLOTS-1:0] pend_q;
  logic [SLOTS-1:0] set_m;
  logic [SLOTS-1:0] clr_m;

  // Pending-sync set/clear masks
  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (note_on) begin
      for (int o = 0; o < V_OSC; o++) begin
        set_m[{cur_key_adr, O_WIDTH'(o)}] = 1'b1;
      end
    end
    if (cap_v) clr_m[slot_r] = 1'b1;
  end

  // Pending bits: a set in the clearing cycle survives to next frame
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) pend_q <= '0;
    else         pend_q <= (pend_q & ~clr_m) | set_m;
  end

  assign sync_hit = cap_v & pend_q[slot_r];
`else
  logic unused_key;
  assign unused_key = ^{note_on, cur_key_adr};
  assign sync_hit   = 1'b0;
`endif

  // Accumulate: a pending sync restarts the phase from zero
  always_comb begin
    base  = sync_hit ? '0 : phase_q[slot_r];
    add_w = {1'b0, base} + (PH_WIDTH + 1)'(pitch_r);
  end

  assign phase_valid = cap_v;
  assign phase_out   = cap_v ? add_w[PH_WIDTH-1:0] : '0;
  assign phase_slot  = cap_v ? slot_r : '0;
  assign wrap        = cap_v & (add_w[PH_WIDTH] | sync_hit);

  // Phase register file write-back
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < SLOTS; i++) phase_q[i] <= '0;
    end else if (cap_v) begin
      phase_q[slot_r] <= add_w[PH_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_osc_phase_accum.sv
// tb_osc_phase_accum: randomized frame-level check of osc_phase_accum
// against a per-slot phase/sync reference model.
module tb_osc_phase_accum;

`ifdef KEY_SYNC_EN
  localparam bit KS = 1'b1;
`else
  localparam bit KS = 1'b0;
`endif

  logic        iCLK;
  logic        iRST_N;
  logic        sample_tick;
  logic [23:0] osc_pitch_val;
  logic        note_on;
  logic [2:0]  cur_key_adr;
  logic [4:0]  slot_adr;
  logic [31:0] phase_out;
  logic [4:0]  phase_slot;
  logic        phase_valid;
  logic        wrap;
  logic        busy;
  logic        overrun;

  logic [23:0] pitch_tab [32];
  logic [31:0] m_phase [32];
  bit          m_pend [32];
  bit          m_ovr;

  int n_cmp;
  int n_bad;
  int frame_no;
  int wrap5_cnt;
  int wrap5_frame;
  logic [31:0] last5;

  osc_phase_accum dut (
    .iCLK          (iCLK),
    .iRST_N        (iRST_N),
    .sample_tick   (sample_tick),
    .osc_pitch_val (osc_pitch_val),
    .note_on       (note_on),
    .cur_key_adr   (cur_key_adr),
    .slot_adr      (slot_adr),
    .phase_out     (phase_out),
    .phase_slot    (phase_slot),
    .phase_valid   (phase_valid),
    .wrap          (wrap),
    .busy          (busy),
    .overrun       (overrun)
  );

  assign osc_pitch_val = pitch_tab[slot_adr];

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_phase[i] = '0;
      m_pend[i]  = 1'b0;
    end
    m_ovr = 1'b0;
  endtask

  task automatic model_note(input int v);
    if (KS) for (int o = 0; o < 4; o++) m_pend[v*4+o] = 1'b1;
  endtask

  task automatic fill_tab(input logic [23:0] v);
    for (int i = 0; i < 32; i++) pitch_tab[i] = v;
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if ({slot_adr, phase_out, phase_slot, phase_valid,
         wrap, busy, overrun} !== '0) begin
      n_bad++;
      $display("FAIL %s: outputs slot_adr=%0d phase_out=%h slot=%0d v=%b w=%b busy=%b ovr=%b, need all 0",
               tag, slot_adr, phase_out, phase_slot, phase_valid,
               wrap, busy, overrun);
    end
  endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    check_zero("reset");
    model_reset();
    @(negedge iCLK);
    @(negedge iCLK);
    iRST_N = 1'b1;
  endtask

  // One frame: note_k = slot whose update cycle carries note_on (-1 none),
  // tick_at / rst_at = frame cycle for an extra tick / reset (-1 none).
  task automatic frame(input int note_k, input int note_v,
                       input int tick_at, input int rst_at);
    logic [32:0] full;
    logic [31:0] base;
    bit          xw;
    int          s;
    frame_no++;
    @(negedge iCLK);
    sample_tick = 1'b1;
    @(negedge iCLK);
    sample_tick = 1'b0;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      if (cyc > 1) @(negedge iCLK);
      note_on     = 1'b0;
      sample_tick = 1'b0;
      if (cyc == rst_at) begin
        iRST_N = 1'b0;
        #1;
        check_zero("mid_reset");
        model_reset();
        @(negedge iCLK);
        iRST_N = 1'b1;
        return;
      end
      n_cmp++;
      if (busy !== (cyc <= 32)) begin
        n_bad++;
        $display("FAIL busy c%0d: got %b need %b", cyc, busy, cyc <= 32);
      end
      n_cmp++;
      if (slot_adr !== ((cyc <= 32) ? 5'(cyc - 1) : 5'd0)) begin
        n_bad++;
        $display("FAIL slot_adr c%0d: got %0d", cyc, slot_adr);
      end
      n_cmp++;
      if (phase_valid !== (cyc >= 2)) begin
        n_bad++;
        $display("FAIL valid c%0d: got %b need %b", cyc, phase_valid, cyc >= 2);
      end
      if (cyc >= 2) begin
        s    = cyc - 2;
        base = m_pend[s] ? 32'd0 : m_phase[s];
        full = {1'b0, base} + {9'd0, pitch_tab[s]};
        xw   = full[32] | m_pend[s];
        m_phase[s] = full[31:0];
        m_pend[s]  = 1'b0;
        n_cmp++;
        if (phase_slot !== 5'(s) || phase_out !== full[31:0] || wrap !== xw) begin
          n_bad++;
          $display("FAIL update f%0d s%0d: got slot=%0d ph=%h w=%b need ph=%h w=%b",
                   frame_no, s, phase_slot, phase_out, wrap, full[31:0], xw);
        end
        if (s == 5) begin
          last5 = phase_out;
          if (wrap === 1'b1) begin
            wrap5_cnt++;
            wrap5_frame = frame_no;
          end
        end
      end
      n_cmp++;
      if (overrun !== m_ovr) begin
        n_bad++;
        $display("FAIL overrun c%0d: got %b need %b", cyc, overrun, m_ovr);
      end
      if (note_k >= 0 && cyc - 2 == note_k) begin
        note_on     = 1'b1;
        cur_key_adr = 3'(note_v);
        model_note(note_v);
      end
      if (cyc == tick_at) begin
        sample_tick = 1'b1;
        m_ovr = 1'b1;
      end
    end
    @(negedge iCLK);
    note_on     = 1'b0;
    sample_tick = 1'b0;
  endtask

  task automatic idle_note(input int v);
    @(negedge iCLK);
    note_on     = 1'b1;
    cur_key_adr = 3'(v);
    model_note(v);
    @(negedge iCLK);
    note_on = 1'b0;
  endtask

  task automatic test_reset();
    fill_tab(24'h000100);
    do_reset();
    @(negedge iCLK);
    check_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    frame(-1, 0, -1, -1);
    frame(-1, 0, -1, -1);
    n_cmp++;
    if (last5 !== 32'h200) begin
      n_bad++;
      $display("FAIL basic2: slot5 phase %h need 00000200", last5);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    fill_tab(24'hFFFFFF);
    wrap5_cnt = 0;
    frame_no  = 0;
    for (int f = 0; f < 257; f++) frame(-1, 0, -1, -1);
    n_cmp++;
    if (last5 !== 32'h00FFFEFF || wrap5_cnt != 1 || wrap5_frame != 257) begin
      n_bad++;
      $display("FAIL wrap257: ph=%h wraps=%0d at f%0d need 00fffeff 1 at 257",
               last5, wrap5_cnt, wrap5_frame);
    end
  endtask

  task automatic test_keysync();
    do_reset();
    fill_tab(24'h000100);
    for (int f = 0; f < 3; f++) frame(-1, 0, -1, -1);
    idle_note(2);
    frame(-1, 0, -1, -1);
    frame(9, 2, -1, -1);
    frame(-1, 0, -1, -1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 32; i++) begin
        pitch_tab[i] = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom);
      end
      if ($urandom_range(0, 1) == 1) idle_note($urandom_range(0, 7));
      frame($urandom_range(0, 1) == 1 ? $urandom_range(0, 31) : -1,
            $urandom_range(0, 7), -1, -1);
    end
  endtask

  task automatic test_overrun();
    frame(-1, 0, 10, -1);
    frame(-1, 0, 32, -1);
    frame(-1, 0, -1, -1);
  endtask

  task automatic test_reset_mid();
    frame(-1, 0, -1, 12);
    fill_tab(24'h000100);
    frame(-1, 0, -1, -1);
    n_cmp++;
    if (last5 !== 32'h100) begin
      n_bad++;
      $display("FAIL reset_mid: slot5 phase %h need 00000100", last5);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    frame_no    = 0;
    wrap5_cnt   = 0;
    wrap5_frame = 0;
    last5       = '0;
    iRST_N      = 1'b1;
    sample_tick = 1'b0;
    note_on     = 1'b0;
    cur_key_adr = '0;
    model_reset();
    test_reset();
    test_basic();
    test_wrap();
    test_keysync();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
